// File: rtl/pid_gate_pkg.sv
// Shared types and gain-sizing helpers for the PID term gate.
// Ramp support is compiled in with the PID_GATE_RAMP_EN macro.
package pid_gate_pkg;

  typedef enum logic [1:0] {
    ZERO      = 2'd0,
    RAMP_UP   = 2'd1,
    PASS      = 2'd2,
    RAMP_DOWN = 2'd3
  } gate_state_t;

  // Gain k spans 0..2^ramp_shift inclusive, hence one extra bit.
  function automatic int gain_width(input int ramp_shift);
    return ramp_shift + 1;
  endfunction

  function automatic int max_gain(input int ramp_shift);
    return 1 << ramp_shift;
  endfunction

endpackage

// File: rtl/pid_term_gate_if.sv
// Sample stream between the term calculators, the gate and the summing stage.
// The master drives the samples and the slave (the gate) returns the gated samples.
interface pid_term_gate_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 3
);

  logic                      in_valid;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       force_zero;
  logic                      out_valid;
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic [CHANNELS-1:0]       ch_busy;

  modport master (
    output in_valid, in_data, force_zero,
    input  out_valid, out_data, ch_busy
  );

  modport slave (
    input  in_valid, in_data, force_zero,
    output out_valid, out_data, ch_busy
  );

endinterface

// File: rtl/pid_gate_ramp.sv
// One gated channel. With PID_GATE_RAMP_EN the gain fades linearly between 0 and full scale.
// Without the macro the channel is a registered pass-or-zero gate.
module pid_gate_ramp
  import pid_gate_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int RAMP_SHIFT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic                    force_zero,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    busy
);

`ifdef PID_GATE_RAMP_EN
  localparam int            KW     = gain_width(RAMP_SHIFT);
  localparam int            PW     = WIDTH + KW;
  localparam logic [KW-1:0] K_MAX  = KW'(max_gain(RAMP_SHIFT));
  localparam logic [KW-1:0] K_ONE  = {{(KW-1){1'b0}}, 1'b1};
  localparam logic [KW-1:0] K_ZERO = {KW{1'b0}};

  gate_state_t             state_r;
  gate_state_t             state_s;
  logic [KW-1:0]           k_r;
  logic [KW-1:0]           k_s;
  logic signed [PW-1:0]    data_ext_s;
  logic signed [PW-1:0]    gain_ext_s;
  logic signed [PW-1:0]    prod_s;
  logic signed [PW-1:0]    scaled_s;
  logic signed [WIDTH-1:0] gated_s;
  logic signed [WIDTH-1:0] out_r;
  logic                    busy_r;

  // Next state and stepped gain; reversals move k by one from wherever it is.
  always_comb begin
    state_s = state_r;
    k_s     = k_r;
    if (in_valid) begin
      case (state_r)
        ZERO: begin
          if (!force_zero) begin
            k_s     = K_ONE;
            state_s = (K_ONE == K_MAX) ? PASS : RAMP_UP;
          end else begin
            k_s     = K_ZERO;
            state_s = ZERO;
          end
        end
        RAMP_UP: begin
          if (!force_zero) begin
            k_s     = k_r + K_ONE;
            state_s = (k_s == K_MAX) ? PASS : RAMP_UP;
          end else begin
            k_s     = k_r - K_ONE;
            state_s = (k_s == K_ZERO) ? ZERO : RAMP_DOWN;
          end
        end
        PASS: begin
          if (force_zero) begin
            k_s     = K_MAX - K_ONE;
            state_s = (k_s == K_ZERO) ? ZERO : RAMP_DOWN;
          end else begin
            k_s     = K_MAX;
            state_s = PASS;
          end
        end
        RAMP_DOWN: begin
          if (force_zero) begin
            k_s     = k_r - K_ONE;
            state_s = (k_s == K_ZERO) ? ZERO : RAMP_DOWN;
          end else begin
            k_s     = k_r + K_ONE;
            state_s = (k_s == K_MAX) ? PASS : RAMP_UP;
          end
        end
        default: begin
          k_s     = K_ZERO;
          state_s = ZERO;
        end
      endcase
    end else begin
      state_s = state_r;
      k_s     = k_r;
    end
  end

  // Scale by the stepped gain; |in*k| fits PW bits because k never exceeds 2^RAMP_SHIFT.
  always_comb begin
    data_ext_s = PW'(in_data);
    gain_ext_s = $signed({{(PW-KW){1'b0}}, k_s});
    prod_s     = data_ext_s * gain_ext_s;
    scaled_s   = prod_s >>> RAMP_SHIFT;
    gated_s    = WIDTH'(scaled_s);
  end

  // State, gain, output and busy registers advance only on accepted samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ZERO;
      k_r     <= K_ZERO;
      out_r   <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
    end else if (in_valid) begin
      state_r <= state_s;
      k_r     <= k_s;
      out_r   <= gated_s;
      busy_r  <= (state_s == RAMP_UP) || (state_s == RAMP_DOWN);
    end
  end

  assign out_data = out_r;
  assign busy     = busy_r;
`else
  logic signed [WIDTH-1:0] out_r;
  logic                    unused_cfg_s;

  assign unused_cfg_s = (RAMP_SHIFT == 0);

  // Hard gate: registered pass or zero on each accepted sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r <= {WIDTH{1'b0}};
    end else if (in_valid) begin
      out_r <= force_zero ? {WIDTH{1'b0}} : in_data;
    end
  end

  assign out_data = out_r;
  assign busy     = 1'b0;
`endif

endmodule

// File: rtl/pid_term_gate.sv
// Multi-channel PID term gate: one pid_gate_ramp per channel plus the valid pipeline.
// Ramping is enabled by defining PID_GATE_RAMP_EN; otherwise channels hard-gate.
module pid_term_gate
  import pid_gate_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int CHANNELS   = 3,
  parameter int RAMP_SHIFT = 4
) (
  input  logic          clk,
  input  logic          rst,
  pid_term_gate_if.slave bus
);

  logic [CHANNELS*WIDTH-1:0] out_data_s;
  logic [CHANNELS-1:0]       busy_s;
  logic                      out_valid_r;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    pid_gate_ramp #(
      .WIDTH      (WIDTH),
      .RAMP_SHIFT (RAMP_SHIFT)
    ) u_ramp (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (bus.in_valid),
      .in_data    (bus.in_data[c*WIDTH +: WIDTH]),
      .force_zero (bus.force_zero[c]),
      .out_data   (out_data_s[c*WIDTH +: WIDTH]),
      .busy       (busy_s[c])
    );
  end

  // Output valid trails the accepted input by exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= bus.in_valid;
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_s;
  assign bus.ch_busy   = busy_s;

endmodule

// File: tb/tb_pid_term_gate.sv
// Scoreboard bench for pid_term_gate (WIDTH=16, CHANNELS=3, RAMP_SHIFT=2).
// Expected vectors follow PID_GATE_RAMP_EN: ramp sequences when defined, hard gating otherwise.
module tb_pid_term_gate;

  localparam int W  = 16;
  localparam int C  = 3;
  localparam int RS = 2;

  typedef struct {
    logic [C*W-1:0] data;
    logic [C-1:0]   busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t exp_q[$];
  exp_t mon_e;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  pid_term_gate_if #(.WIDTH(W), .CHANNELS(C)) bus ();

  pid_term_gate #(
    .WIDTH      (W),
    .CHANNELS   (C),
    .RAMP_SHIFT (RS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  function automatic logic [C*W-1:0] pk(input logic signed [W-1:0] a,
                                        input logic signed [W-1:0] b,
                                        input logic signed [W-1:0] c2);
    return {c2, b, a};
  endfunction

  task automatic check(input string name, input logic [C*W-1:0] act, input logic [C*W-1:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic send(input logic [C-1:0] fz, input logic [C*W-1:0] din,
                      input logic [C*W-1:0] dexp, input logic [C-1:0] bexp);
    exp_t e;
    bus.in_valid   = 1'b1;
    bus.in_data    = din;
    bus.force_zero = fz;
    e.data = dexp;
    e.busy = bexp;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_idle_state(input string tag, input logic [C*W-1:0] dexp, input logic [C-1:0] bexp);
    check({tag, "_out_valid"}, {47'd0, bus.out_valid}, {47'd0, 1'b0});
    check({tag, "_out_data"}, bus.out_data, dexp);
    check({tag, "_ch_busy"}, {45'd0, bus.ch_busy}, {45'd0, bexp});
  endtask

  // Monitor: every presented output is matched against the oldest pending expectation.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_valid: got out_valid=1, expected no pending output");
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_out_data", bus.out_data, mon_e.data);
        check("sb_ch_busy", {45'd0, bus.ch_busy}, {45'd0, mon_e.busy});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_data    = {(C*W){1'b0}};
    bus.force_zero = {C{1'b0}};
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle_state("reset", {(C*W){1'b0}}, 3'b000);

`ifdef PID_GATE_RAMP_EN
    // Ramp up on all channels, ch2 negative exercises floor rounding.
    send(3'b000, pk(16'sd1000, 16'sd1000, -16'sd1001), pk(16'sd250,  16'sd250,  -16'sd251),  3'b111);
    send(3'b000, pk(16'sd1000, 16'sd1000, -16'sd1001), pk(16'sd500,  16'sd500,  -16'sd501),  3'b111);
    send(3'b000, pk(16'sd1000, 16'sd1000, -16'sd1001), pk(16'sd750,  16'sd750,  -16'sd751),  3'b111);
    send(3'b000, pk(16'sd1000, 16'sd1000, -16'sd1001), pk(16'sd1000, 16'sd1000, -16'sd1001), 3'b000);
    send(3'b000, pk(16'sd1000, 16'sd1000, -16'sd1001), pk(16'sd1000, 16'sd1000, -16'sd1001), 3'b000);
    // Ramp ch1 down to zero from PASS.
    send(3'b010, pk(16'sd1000, 16'sd1000, -16'sd1001), pk(16'sd1000, 16'sd750, -16'sd1001), 3'b010);
    send(3'b010, pk(16'sd1000, 16'sd1000, -16'sd1001), pk(16'sd1000, 16'sd500, -16'sd1001), 3'b010);
    send(3'b010, pk(16'sd1000, 16'sd1000, -16'sd1001), pk(16'sd1000, 16'sd250, -16'sd1001), 3'b010);
    send(3'b010, pk(16'sd1000, 16'sd1000, -16'sd1001), pk(16'sd1000, 16'sd0,   -16'sd1001), 3'b000);
    send(3'b010, pk(16'sd1000, 16'sd1000, -16'sd1001), pk(16'sd1000, 16'sd0,   -16'sd1001), 3'b000);
    // Reversal mid-ramp on ch1.
    send(3'b000, pk(-16'sd7, 16'sd400, 16'sd123), pk(-16'sd7, 16'sd100, 16'sd123), 3'b010);
    send(3'b000, pk(-16'sd7, 16'sd400, 16'sd123), pk(-16'sd7, 16'sd200, 16'sd123), 3'b010);
    send(3'b010, pk(-16'sd7, 16'sd400, 16'sd123), pk(-16'sd7, 16'sd100, 16'sd123), 3'b010);
    send(3'b010, pk(-16'sd7, 16'sd400, 16'sd123), pk(-16'sd7, 16'sd0,   16'sd123), 3'b000);
    // Opposite transitions on different channels in the same sample.
    send(3'b101, pk(-16'sd4, 16'sd8, 16'sd100), pk(-16'sd3, 16'sd2, 16'sd75), 3'b111);
    idle(3);
    check_idle_state("gap_hold", pk(-16'sd3, 16'sd2, 16'sd75), 3'b111);
    send(3'b101, pk(-16'sd4, 16'sd8, 16'sd100), pk(-16'sd2, 16'sd4, 16'sd50), 3'b111);
    send(3'b101, pk(-16'sd4, 16'sd8, 16'sd100), pk(-16'sd1, 16'sd6, 16'sd25), 3'b111);
    // Reset with ch1 at k=3 must clear outputs and gains.
    do_reset();
    check_idle_state("mid_ramp_reset", {(C*W){1'b0}}, 3'b000);
    send(3'b000, pk(16'sd1000, 16'sd1000, 16'sd1000), pk(16'sd250, 16'sd250, 16'sd250), 3'b111);
`else
    send(3'b000, pk(16'sh7FFF, -16'sd1001, 16'sd1000), pk(16'sh7FFF, -16'sd1001, 16'sd1000), 3'b000);
    send(3'b111, pk(16'sh7FFF, -16'sd1001, 16'sd1000), pk(16'sd0, 16'sd0, 16'sd0), 3'b000);
    send(3'b010, pk(16'sh7FFF, 16'sh7FFF, 16'sh7FFF), pk(16'sh7FFF, 16'sd0, 16'sh7FFF), 3'b000);
    send(3'b101, pk(16'sh7FFF, 16'sh7FFF, 16'sh7FFF), pk(16'sd0, 16'sh7FFF, 16'sd0), 3'b000);
    send(3'b000, pk(16'sh8000, 16'sh7FFF, -16'sd1), pk(16'sh8000, 16'sh7FFF, -16'sd1), 3'b000);
    send(3'b001, pk(16'sh7FFF, 16'sd5, 16'sd6), pk(16'sd0, 16'sd5, 16'sd6), 3'b000);
    idle(3);
    check_idle_state("gap_hold", pk(16'sd0, 16'sd5, 16'sd6), 3'b000);
    do_reset();
    check_idle_state("post_reset", {(C*W){1'b0}}, 3'b000);
    send(3'b100, pk(16'sh7FFF, 16'sh7FFF, 16'sh7FFF), pk(16'sh7FFF, 16'sh7FFF, 16'sd0), 3'b000);
`endif

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) idle(1);
    idle(1);
    check("queue_drained", (C*W)'(exp_q.size()), {(C*W){1'b0}});
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
